// File: rtl/fp_mul_dispatch.sv
// rtl/fp_mul_dispatch.sv - request queue, issue FSM and result return for the fp32 multiplier
//
// Buffers {a, b, tag} requests, issues them one at a time to the multiplier
// through its start/busy/output_done handshake, classifies each result and
// returns it with its tag and flags. A watchdog aborts a multiplier that
// never completes; sticky flags accumulate over accepted results.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        request stream handshake
//   in_a, in_b, in_tag       request operands and tag
//   mul_start, mul_rst       multiplier start pulse, multiplier reset (active high)
//   mul_a, mul_b             operands held for the multiplier
//   mul_busy, mul_done,
//   mul_z                    multiplier busy, output_done and result
//   out_valid/out_ready      result stream handshake
//   out_z, out_tag,
//   out_flags                result word, tag and {timeout, nan, inf, zero}
//   sticky_flags, clr_flags  accumulated flags and their clear

module fp_mul_dispatch #(
    parameter int TAG_W   = 4,
    parameter int Q_DEPTH = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic             mul_rst,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_busy,
    input  logic             mul_done,
    input  logic [31:0]      mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    input  logic             clr_flags
);

    localparam int PTR_W   = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 64 + TAG_W;

    // The counter reads k-1 in the k-th cycle after the mul_start cycle, so
    // leaving at this value lands ABORT exactly TIMEOUT cycles after mul_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ABORT,
        S_OUT
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Request queue. The head stays resident while in flight and is only
    // popped when its result (or abort) is captured.
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] q_mem [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     q_count;
    logic               q_full, q_empty;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;
    logic [31:0]        head_a, head_b;
    logic [TAG_W-1:0]   head_tag;

    assign q_full   = (q_count == (PTR_W+1)'(Q_DEPTH));
    assign q_empty  = (q_count == '0);
    assign in_ready = rst & ~q_full;
    assign push     = in_valid & in_ready;

    assign head     = q_mem[rd_ptr];
    assign head_a   = head[ENTRY_W-1 -: 32];
    assign head_b   = head[TAG_W +: 32];
    assign head_tag = head[TAG_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {in_a, in_b, in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_hit;

    assign timeout_hit = (wd_cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    logic load_ops;
    logic capture;
    logic abort_load;
    logic handshake;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_ops   = 1'b0;
        capture    = 1'b0;
        abort_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    load_ops   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // output_done may still be high from the previous operation
                // until busy rises, so it is deliberately not looked at here.
                if (mul_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_WAIT_DONE: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (!mul_busy && mul_done) begin
                    capture    = 1'b1;
                    pop        = 1'b1;
                    state_next = S_OUT;
                end else if (timeout_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                abort_load = 1'b1;
                pop        = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mul_start = (state == S_ISSUE);
    assign out_valid = (state == S_OUT);
    // Holds the multiplier in reset for as long as the system reset is low.
    assign mul_rst   = ~rst | (state == S_ABORT);
    assign handshake = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Operand and result registers
    // ------------------------------------------------------------------
    function automatic logic [2:0] classify(input logic [30:0] z);
        logic exp_max;
        logic man_zero;
        exp_max  = (z[30:23] == 8'hFF);
        man_zero = (z[22:0] == 23'd0);
        return {exp_max & ~man_zero, exp_max & man_zero, z == 31'd0};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (load_ops) begin
            mul_a <= head_a;
            mul_b <= head_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_z     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (capture) begin
            out_z     <= mul_z;
            out_tag   <= head_tag;
            out_flags <= {1'b0, classify(mul_z[30:0])};
        end else if (abort_load) begin
            out_z     <= QNAN;
            out_tag   <= head_tag;
            out_flags <= 4'b1100;
        end
    end

    // A clear coinciding with a handshake keeps the newly delivered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_flags <= '0;
        end else if (clr_flags && handshake) begin
            sticky_flags <= out_flags;
        end else if (clr_flags) begin
            sticky_flags <= '0;
        end else if (handshake) begin
            sticky_flags <= sticky_flags | out_flags;
        end
    end

endmodule

// File: doc/fp_mul_dispatch.md
# fp_mul_dispatch

Request front-end for the 32-bit floating-point multiplier. It buffers operand pairs arriving on a valid/ready stream and issues each to the multiplier through its start/busy/output_done handshake. It captures the result, classifies it, and returns it on a valid/ready output stream with a tag and per-result flags. A watchdog aborts a multiplier that never completes, and sticky status flags accumulate across operations.

## Interface
- TAG_W, 4: width of the transaction tag carried alongside the operands.
- Q_DEPTH, 2: input queue depth, power of two, at least 2.
- TIMEOUT, 64: maximum cycles allowed from `mul_start` to completion before abort.

One clock; reset is asynchronous and active-low.

- clk  in  1  clock, all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept a request.
- in_a, in_b  in  32  IEEE-754 single-precision operands.
- in_tag  in  TAG_W  request tag.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_rst  out  1  active-high synchronous reset to the multiplier.
- mul_a, mul_b  out  32  operands held stable from ISSUE until the result is captured.
- mul_busy, mul_done  in  1  multiplier `busy` and `output_done`.
- mul_z  in  32  multiplier result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_z  out  32  result word.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  4  {timeout, nan, inf, zero} for this result.
- sticky_flags  out  4  OR of out_flags over all accepted results.
- clr_flags  in  1  clears sticky_flags.

## Operation
- Queue: FIFO of {a, b, tag}.
  - Push when in_valid & in_ready. in_ready = !full.
  - The head entry stays in the queue while in flight and is popped on capture or abort.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, OUT.
  - IDLE: if the queue is non-empty, go to ISSUE.
  - ISSUE: mul_start=1 for this single cycle, with mul_a/mul_b driven from the head entry. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for mul_busy=1, then go to WAIT_DONE.
    - mul_done is ignored here. The multiplier leaves output_done high from the previous operation until busy rises.
  - WAIT_DONE: when mul_busy=0 & mul_done=1, register mul_z and the head tag into out_z/out_tag, compute flags, pop, go to OUT.
  - ABORT: mul_rst=1 for one cycle. out_z=32'h7FC00000, flags=timeout|nan, head tag, pop, go to OUT.
  - OUT: out_valid=1 and outputs held. On out_ready, go to IDLE.
- Watchdog: counter cleared in ISSUE and incremented in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT, go to ABORT; completion in that same cycle wins.
- Flags, computed from the captured word only (the multiplier's overflow/underflow outputs are not used):
  - zero = z[30:0]==0.
  - inf = z[30:23]==8'hFF & z[22:0]==0.
  - nan = z[30:23]==8'hFF & z[22:0]!=0.
  - timeout set only in ABORT.
- Sticky flags:
  - On the out_valid&out_ready handshake, sticky_flags |= out_flags.
  - clr_flags zeroes them.
  - When clr_flags coincides with a handshake, the clear applies first and the new flags are retained.
- mul_rst = !rst | abort pulse, so the multiplier is held reset during system reset.
- Queue push and pop may occur in the same cycle; occupancy is then unchanged.

## Timing
- Reset values:
  - in_ready=1 after release, 0 while rst=0.
  - out_valid=0, out_z=0, out_tag=0, out_flags=0, sticky_flags=0.
  - mul_start=0, mul_a=0, mul_b=0.
  - FSM=IDLE, queue empty, counter 0.
- With the FSM idle and the queue empty, a request accepted at edge T produces mul_start high during cycle T+1.
- out_valid rises one cycle after the cycle in which mul_busy=0 & mul_done=1 is first sampled in WAIT_DONE.
- Dispatcher overhead is 3 cycles plus one cycle back to IDLE after the output handshake. There is one operation in flight at a time.
- Reset asserted mid-operation: immediate return to reset values, queue flushed, no output produced for the in-flight request. The multiplier is reset by mul_rst.
- Results leave in request order.

## Test plan
- 0x40400000 × 0x40000000, tag 5 -> out_z=0x40C00000, out_tag=5, out_flags=4'b0000, exactly one mul_start pulse.
- 0x7F800000 × 0x00000000 -> out_z=0xFFC00000, out_flags=4'b0100, sticky_flags=4'b0100.
- Three back-to-back requests with out_ready low for 40 cycles -> in_ready drops after 2 accepted. All three results arrive in order with correct tags once out_ready rises.
- Multiplier model keeps busy high forever -> mul_rst pulses at TIMEOUT=64 cycles after mul_start. out_z=0x7FC00000, out_flags=4'b1100.
- rst pulled low during WAIT_DONE, then a new request -> no result for the old tag. The stale mul_done=1 is not taken as completion, and the new result is correct.
- 0x7F000000 × 0x7F000000 with clr_flags asserted on its output handshake, after an earlier zero result -> out_z=0x7F800000, sticky_flags=4'b0010.
